// File: rtl/aib_rx_filter.sv
// AIB receive pad filter: polarity select, N-flop synchronizer,
// deglitch FSM with edge pulses and a saturating accepted-edge counter.
module aib_rx_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RXPAD,
    input  logic             C_EN,
    input  logic             C_INV,
    input  logic [2:0]       C_FILT,
    input  logic             C_CLR,
    output logic             rx_data,
    output logic             rx_rise,
    output logic             rx_fall,
    output logic             rx_glitch,
    output logic [CNT_W-1:0] edge_cnt
);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        STABLE  = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nstate;
    logic [2:0]             r_cnt;
    logic [2:0]             w_ncnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_data;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_glitch;
    logic [CNT_W-1:0]       r_ecnt;
    logic                   w_p;
    logic                   w_s;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_glitch;
    logic                   w_sat;

    assign w_p   = RXPAD ^ C_INV;
    assign w_s   = r_sync[SYNC_STAGES-1];
    assign w_sat = &r_ecnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_p};
        end
    end

    // cnt counts cycles already spent in PENDING; accept once it reaches N
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_load   = 1'b0;
        w_accept = 1'b0;
        w_glitch = 1'b0;
        if (!C_EN) begin
            w_nstate = OFF;
            w_ncnt   = 3'd0;
        end else begin
            unique case (r_state)
                OFF: begin
                    w_load   = 1'b1;
                    w_nstate = STABLE;
                    w_ncnt   = 3'd0;
                end
                STABLE: begin
                    if (w_s != r_data) begin
                        if (C_FILT == 3'd0) begin
                            w_accept = 1'b1;
                        end else begin
                            w_nstate = PENDING;
                            w_ncnt   = 3'd1;
                        end
                    end
                end
                PENDING: begin
                    if (w_s == r_data) begin
                        w_glitch = 1'b1;
                        w_nstate = STABLE;
                        w_ncnt   = 3'd0;
                    end else if (r_cnt >= C_FILT) begin
                        w_accept = 1'b1;
                        w_nstate = STABLE;
                        w_ncnt   = 3'd0;
                    end else begin
                        w_ncnt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_nstate = OFF;
                    w_ncnt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= OFF;
            r_cnt    <= 3'd0;
            r_data   <= RST_VAL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
            r_ecnt   <= '0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            if (w_load || w_accept) begin
                r_data <= w_s;
            end
            r_rise   <= w_accept & w_s;
            r_fall   <= w_accept & ~w_s;
            r_glitch <= w_glitch;
            if (C_CLR) begin
                r_ecnt <= '0;
            end else if (w_accept && !w_sat) begin
                r_ecnt <= r_ecnt + 1'b1;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_rise   = r_rise;
    assign rx_fall   = r_fall;
    assign rx_glitch = r_glitch;
    assign edge_cnt  = r_ecnt;

endmodule

// File: doc/aib_rx_filter.md
AIB_RX_FILTER -- requirements
Module: aib_rx_filter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SYNC_STAGES, 2, synchronizer depth; legal 2..4
  CNT_W, 16, accepted-edge counter width
  RST_VAL, 1'b0, rx_data value at and after reset
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, receive clock
  rst, in, 1, synchronous active-high reset
  RXPAD, in, 1, asynchronous pad receiver output
  C_EN, in, 1, filter enable
  C_INV, in, 1, invert pad polarity before the synchronizer
  C_FILT, in, 3, deglitch length N (0..7)
  C_CLR, in, 1, synchronous clear of edge_cnt
  rx_data, out, 1, filtered, synchronized pad level
  rx_rise, out, 1, one-cycle pulse on accepted 0->1
  rx_fall, out, 1, one-cycle pulse on accepted 1->0
  rx_glitch, out, 1, one-cycle pulse when a pending transition is abandoned
  edge_cnt, out, CNT_W, saturating count of accepted edges
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst); no other clock or asynchronous reset.

Function
REQ-004 The input SHALL be p = RXPAD ^ C_INV, passed through SYNC_STAGES flops; the last stage is s.
REQ-005 The FSM SHALL have the states OFF, STABLE and PENDING, plus a 3-bit counter cnt.
REQ-006 OFF: all pulses are 0 and rx_data holds its value. When C_EN=1, the FSM SHALL load rx_data<=s and go to STABLE, with no rise or fall pulse.
REQ-007 STABLE: if s==rx_data, the FSM stays. If s!=rx_data and N==0, it SHALL accept the edge in that cycle. If s!=rx_data and N>0, it SHALL go to PENDING with cnt<=1.
REQ-008 PENDING: if s==rx_data, the FSM SHALL pulse rx_glitch on the next cycle and return to STABLE. If s!=rx_data and cnt==N, it SHALL accept the edge. Otherwise cnt<=cnt+1.
REQ-009 Accepting an edge SHALL:
  - set rx_data<=s;
  - pulse rx_rise or rx_fall on the same edge that rx_data changes, registered and exactly one cycle wide;
  - return the FSM to STABLE.
REQ-010 Latency: a clean level change is first sampled at edge 1. rx_data SHALL change at edge SYNC_STAGES+1+N. Pulses of N cycles or fewer at s SHALL never change rx_data.
REQ-011 C_FILT SHALL be sampled every cycle. If C_FILT is reduced while PENDING and cnt>=new N, the edge SHALL be accepted that cycle.
REQ-012 C_EN=0 in any state SHALL force OFF on the next edge. A pending transition SHALL be dropped without an rx_glitch pulse.
REQ-013 edge_cnt SHALL increment by 1 on each accepted edge and saturate at 2^CNT_W-1. C_CLR SHALL set it to 0. If C_CLR coincides with an accepted edge, the result SHALL be 0; clear wins.
REQ-014 rx_rise, rx_fall and rx_glitch SHALL be mutually exclusive in every cycle.
REQ-015 C_INV changes SHALL be treated as ordinary input transitions; no special bypass.

Reset
REQ-016 While rst=1, the block SHALL:
  - set every synchronizer flop to RST_VAL^C_INV-independent RST_VAL;
  - set rx_data=RST_VAL;
  - set rx_rise, rx_fall and rx_glitch to 0;
  - set edge_cnt=0, cnt=0, FSM=OFF.
REQ-017 rst asserted mid-PENDING SHALL abandon the transition with no pulse. After rst deasserts, the first sampled cycle SHALL follow REQ-006.
REQ-018 All outputs SHALL be driven from flops; no combinational path from RXPAD to any output.

Verification
REQ-019 Setup SYNC_STAGES=2, N=0, C_EN=1. Stimulus: RXPAD 0->1 sampled at edge 1. Required: rx_data=1 and a single rx_rise at edge 3; edge_cnt=1.
REQ-020 Setup N=3. Stimulus: RXPAD high for 3 cycles, then low. Required: rx_data stays 0, one rx_glitch pulse, edge_cnt unchanged. Repeat with RXPAD high for 4 cycles: rx_rise at edge 6.
REQ-021 Setup CNT_W=4, toggle source. Stimulus: 20 accepted edges. Required: edge_cnt saturates at 15. Assert C_CLR in the same cycle as an accepted edge: edge_cnt=0.
REQ-022 Setup N=7. Stimulus: enter PENDING with cnt=4, then change C_FILT to 2. Required: edge accepted on that cycle's edge.
REQ-023 Stimulus: deassert C_EN during PENDING, and separately assert rst during PENDING. Required: no pulses in either case; rx_data holds (C_EN case) or goes to RST_VAL (rst case). Re-enable with s!=rx_data: rx_data follows with no rise or fall pulse.
REQ-024 Setup C_INV=1. Stimulus: RXPAD held 0 after enable. Required: rx_data=1 after sync latency, with no rx_rise pulse (via OFF load). Then RXPAD 0->1: rx_fall pulses.
